// File: rtl/pulse_generator_core.sv
// Per-channel pulse timing engine: arms on enable, starts on a matching PPS edge,
// then emits a periodic pulse counted in microsecond ticks.
module pulse_generator_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_pulse_enable,
    input  logic [DATA_WIDTH-1:0] i_usr_year_h,
    input  logic [DATA_WIDTH-1:0] i_usr_year_l,
    input  logic [DATA_WIDTH-1:0] i_usr_month,
    input  logic [DATA_WIDTH-1:0] i_usr_day,
    input  logic [DATA_WIDTH-1:0] i_usr_hour,
    input  logic [DATA_WIDTH-1:0] i_usr_minutes,
    input  logic [DATA_WIDTH-1:0] i_usr_seconds,
    input  logic [DATA_WIDTH-1:0] i_width_high_3,
    input  logic [DATA_WIDTH-1:0] i_width_high_2,
    input  logic [DATA_WIDTH-1:0] i_width_high_1,
    input  logic [DATA_WIDTH-1:0] i_width_high_0,
    input  logic [DATA_WIDTH-1:0] i_width_period_3,
    input  logic [DATA_WIDTH-1:0] i_width_period_2,
    input  logic [DATA_WIDTH-1:0] i_width_period_1,
    input  logic [DATA_WIDTH-1:0] i_width_period_0,
    input  logic [DATA_WIDTH-1:0] i_cur_year_h,
    input  logic [DATA_WIDTH-1:0] i_cur_year_l,
    input  logic [DATA_WIDTH-1:0] i_cur_month,
    input  logic [DATA_WIDTH-1:0] i_cur_day,
    input  logic [DATA_WIDTH-1:0] i_cur_hour,
    input  logic [DATA_WIDTH-1:0] i_cur_minutes,
    input  logic [DATA_WIDTH-1:0] i_cur_seconds,
    input  logic                  i_pps,
    input  logic                  i_tick_us,
    output logic                  o_pulse,
    output logic                  o_running,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_RUNNING = 2'b10
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_sh_high, w_sh_high_nxt;
    logic [CNT_WIDTH-1:0] r_sh_per, w_sh_per_nxt;
    logic [CNT_WIDTH-1:0] w_high, w_period, w_cnt_inc;
    logic                 r_pulse, w_pulse_nxt;
    logic                 r_running;
    logic                 w_en, w_imm, w_match;
    logic                 w_unused;

    assign w_en     = i_pulse_enable[0];
    assign w_imm    = i_pulse_enable[1];
    assign w_unused = &{1'b0, i_pulse_enable[DATA_WIDTH-1:2]};

    assign w_high   = CNT_WIDTH'({i_width_high_3, i_width_high_2, i_width_high_1, i_width_high_0});
    assign w_period = CNT_WIDTH'({i_width_period_3, i_width_period_2, i_width_period_1, i_width_period_0});

    assign w_match = (i_cur_year_h  == i_usr_year_h)  && (i_cur_year_l  == i_usr_year_l) &&
                     (i_cur_month   == i_usr_month)   && (i_cur_day     == i_usr_day)    &&
                     (i_cur_hour    == i_usr_hour)    && (i_cur_minutes == i_usr_minutes) &&
                     (i_cur_seconds == i_usr_seconds);

    assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);

    // Next-state, counter, shadow and pulse logic; disable overrides everything.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sh_high_nxt = r_sh_high;
        w_sh_per_nxt  = r_sh_per;
        w_pulse_nxt   = r_pulse;

        if (!w_en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_pulse_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b0;
                    if (w_period != '0) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    w_pulse_nxt = 1'b0;
                    if (i_pps && (w_imm || w_match)) begin
                        // A zero period cannot run; fall back rather than count unbounded.
                        if (w_period == '0) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt   = ST_RUNNING;
                            w_sh_high_nxt = w_high;
                            w_sh_per_nxt  = w_period;
                            w_cnt_nxt     = '0;
                            w_pulse_nxt   = (w_high != '0);
                        end
                    end
                end
                ST_RUNNING: begin
                    if (i_tick_us) begin
                        if (w_cnt_inc == r_sh_per) begin
                            // Period boundary: pick up live configuration.
                            w_cnt_nxt = '0;
                            if (w_period == '0) begin
                                w_state_nxt = ST_IDLE;
                                w_pulse_nxt = 1'b0;
                            end else begin
                                w_sh_high_nxt = w_high;
                                w_sh_per_nxt  = w_period;
                                w_pulse_nxt   = (w_high != '0);
                            end
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                            w_pulse_nxt = (w_cnt_inc < r_sh_high);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_sh_high <= '0;
            r_sh_per  <= '0;
            r_pulse   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sh_high <= w_sh_high_nxt;
            r_sh_per  <= w_sh_per_nxt;
            r_pulse   <= w_pulse_nxt;
            r_running <= (w_state_nxt == ST_RUNNING);
        end
    end

    assign o_pulse   = r_pulse;
    assign o_running = r_running;
    assign o_state   = r_state;

endmodule

// File: tb/tb_pulse_generator_core.sv
// Directed bench for pulse_generator_core: a vector table for short scenarios plus
// hand-written multi-period sequences, all with hand-computed expectations.
module tb_pulse_generator_core;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ARM  = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_pulse_enable;
    logic [7:0] i_usr_year_h, i_usr_year_l, i_usr_month, i_usr_day;
    logic [7:0] i_usr_hour, i_usr_minutes, i_usr_seconds;
    logic [7:0] i_width_high_3, i_width_high_2, i_width_high_1, i_width_high_0;
    logic [7:0] i_width_period_3, i_width_period_2, i_width_period_1, i_width_period_0;
    logic [7:0] i_cur_year_h, i_cur_year_l, i_cur_month, i_cur_day;
    logic [7:0] i_cur_hour, i_cur_minutes, i_cur_seconds;
    logic       i_pps, i_tick_us;
    logic       o_pulse, o_running;
    logic [1:0] o_state;

    int n_vec = 0;
    int n_mis = 0;

    pulse_generator_core dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pulse_enable(i_pulse_enable),
        .i_usr_year_h(i_usr_year_h), .i_usr_year_l(i_usr_year_l), .i_usr_month(i_usr_month),
        .i_usr_day(i_usr_day), .i_usr_hour(i_usr_hour), .i_usr_minutes(i_usr_minutes),
        .i_usr_seconds(i_usr_seconds),
        .i_width_high_3(i_width_high_3), .i_width_high_2(i_width_high_2),
        .i_width_high_1(i_width_high_1), .i_width_high_0(i_width_high_0),
        .i_width_period_3(i_width_period_3), .i_width_period_2(i_width_period_2),
        .i_width_period_1(i_width_period_1), .i_width_period_0(i_width_period_0),
        .i_cur_year_h(i_cur_year_h), .i_cur_year_l(i_cur_year_l), .i_cur_month(i_cur_month),
        .i_cur_day(i_cur_day), .i_cur_hour(i_cur_hour), .i_cur_minutes(i_cur_minutes),
        .i_cur_seconds(i_cur_seconds),
        .i_pps(i_pps), .i_tick_us(i_tick_us),
        .o_pulse(o_pulse), .o_running(o_running), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  en;
        logic        pps;
        logic        tick;
        int          sel;
        logic [31:0] high;
        logic [31:0] period;
        logic        ep;
        logic [1:0]  es;
    } vec_t;

    vec_t vt[20];

    task automatic set_cfg(input logic [7:0] en, input logic [31:0] high, input logic [31:0] period);
        i_pulse_enable = en;
        {i_width_high_3, i_width_high_2, i_width_high_1, i_width_high_0} = high;
        {i_width_period_3, i_width_period_2, i_width_period_1, i_width_period_0} = period;
    endtask

    // sel 0 = current time equals start time; 1/2/3 = seconds/year_l/day differ
    task automatic set_cur(input int sel);
        i_cur_year_h  = 8'd20;
        i_cur_year_l  = (sel == 2) ? 8'd25 : 8'd24;
        i_cur_month   = 8'd3;
        i_cur_day     = (sel == 3) ? 8'd16 : 8'd15;
        i_cur_hour    = 8'd10;
        i_cur_minutes = 8'd20;
        i_cur_seconds = (sel == 1) ? 8'd31 : 8'd30;
    endtask

    task automatic check(input string name, input logic ep, input logic [1:0] es);
        logic er;
        er = (es == S_RUN);
        n_vec++;
        if (o_pulse !== ep || o_state !== es || o_running !== er) begin
            n_mis++;
            $display("FAIL %s: got pulse=%b state=%b running=%b, expected pulse=%b state=%b running=%b",
                     name, o_pulse, o_state, o_running, ep, es, er);
        end
    endtask

    task automatic cyc(input logic pps, input logic tick, input int sel, input string name,
                       input logic ep, input logic [1:0] es);
        i_pps     = pps;
        i_tick_us = tick;
        set_cur(sel);
        @(posedge i_clk);
        #1;
        check(name, ep, es);
    endtask

    initial begin
        int c;
        i_usr_year_h  = 8'd20; i_usr_year_l = 8'd24; i_usr_month   = 8'd3;
        i_usr_day     = 8'd15; i_usr_hour   = 8'd10; i_usr_minutes = 8'd20;
        i_usr_seconds = 8'd30;

        //            en     pps   tick  sel high     period   ep    es
        vt[0]  = '{8'h00, 1'b0, 1'b0, 0, 32'd1,   32'd2,   1'b0, S_IDLE};
        vt[1]  = '{8'h01, 1'b0, 1'b0, 0, 32'd1,   32'd0,   1'b0, S_IDLE};
        vt[2]  = '{8'h03, 1'b0, 1'b0, 0, 32'd1,   32'd2,   1'b0, S_ARM };
        vt[3]  = '{8'h03, 1'b0, 1'b1, 0, 32'd1,   32'd2,   1'b0, S_ARM };
        vt[4]  = '{8'h03, 1'b1, 1'b0, 1, 32'd1,   32'd2,   1'b1, S_RUN };
        vt[5]  = '{8'h03, 1'b0, 1'b1, 0, 32'd1,   32'd2,   1'b0, S_RUN };
        vt[6]  = '{8'h03, 1'b0, 1'b0, 0, 32'd1,   32'd2,   1'b0, S_RUN };
        vt[7]  = '{8'h03, 1'b0, 1'b1, 0, 32'd1,   32'd2,   1'b1, S_RUN };
        vt[8]  = '{8'h03, 1'b0, 1'b1, 0, 32'd1,   32'd2,   1'b0, S_RUN };
        vt[9]  = '{8'h03, 1'b1, 1'b1, 2, 32'd1,   32'd2,   1'b1, S_RUN };
        vt[10] = '{8'h03, 1'b0, 1'b1, 0, 32'd1,   32'd2,   1'b0, S_RUN };
        vt[11] = '{8'h00, 1'b0, 1'b1, 0, 32'd1,   32'd2,   1'b0, S_IDLE};
        vt[12] = '{8'h03, 1'b0, 1'b0, 0, 32'd0,   32'd2,   1'b0, S_ARM };
        vt[13] = '{8'h03, 1'b1, 1'b0, 0, 32'd0,   32'd2,   1'b0, S_RUN };
        vt[14] = '{8'h03, 1'b0, 1'b1, 0, 32'd0,   32'd2,   1'b0, S_RUN };
        vt[15] = '{8'h03, 1'b0, 1'b1, 0, 32'd0,   32'd2,   1'b0, S_RUN };
        vt[16] = '{8'h03, 1'b0, 1'b1, 0, 32'd200, 32'd100, 1'b0, S_RUN };
        vt[17] = '{8'h03, 1'b0, 1'b1, 0, 32'd200, 32'd100, 1'b1, S_RUN };
        vt[18] = '{8'h03, 1'b0, 1'b1, 0, 32'd200, 32'd100, 1'b1, S_RUN };
        vt[19] = '{8'h03, 1'b0, 1'b1, 0, 32'd200, 32'd100, 1'b1, S_RUN };

        i_rst = 1'b1;
        i_pps = 1'b0;
        i_tick_us = 1'b0;
        set_cfg(8'h00, 32'd0, 32'd0);
        set_cur(0);
        repeat (2) @(posedge i_clk);
        #1;
        check("reset", 1'b0, S_IDLE);
        i_rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            set_cfg(vt[i].en, vt[i].high, vt[i].period);
            cyc(vt[i].pps, vt[i].tick, vt[i].sel, $sformatf("vec%0d", i), vt[i].ep, vt[i].es);
        end

        // HIGH >= PERIOD stays high across a boundary; counter is 2 here
        for (int k = 1; k <= 150; k++) cyc(1'b0, 1'b1, 0, $sformatf("always_hi%0d", k), 1'b1, S_RUN);
        // counter is 52; PERIOD=0 takes effect only at the next boundary
        set_cfg(8'h03, 32'd200, 32'd0);
        for (int k = 1; k <= 47; k++) cyc(1'b0, 1'b1, 0, $sformatf("p0_wait%0d", k), 1'b1, S_RUN);
        cyc(1'b0, 1'b1, 0, "p0_relatch", 1'b0, S_IDLE);
        cyc(1'b0, 1'b0, 0, "p0_stay_idle", 1'b0, S_IDLE);

        // Time-matched start, 10/100, then PERIOD=50 written at counter 30
        set_cfg(8'h01, 32'd10, 32'd100);
        cyc(1'b0, 1'b0, 0, "t1_arm", 1'b0, S_ARM);
        cyc(1'b1, 1'b0, 1, "t1_nomatch_sec", 1'b0, S_ARM);
        cyc(1'b1, 1'b0, 2, "t1_nomatch_year", 1'b0, S_ARM);
        cyc(1'b1, 1'b0, 3, "t1_nomatch_day", 1'b0, S_ARM);
        cyc(1'b1, 1'b1, 0, "t1_start", 1'b1, S_RUN);
        for (int k = 1; k <= 350; k++) begin
            if (k == 131) set_cfg(8'h01, 32'd10, 32'd50);
            c = (k < 200) ? (k % 100) : ((k - 200) % 50);
            cyc((k == 50), 1'b1, 0, $sformatf("t1_tick%0d", k), (c < 10), S_RUN);
            if (k % 7 == 0) cyc(1'b0, 1'b0, 0, $sformatf("t1_hold%0d", k), (c < 10), S_RUN);
        end

        // Disable with pulse high and a concurrent tick
        set_cfg(8'h00, 32'd10, 32'd50);
        cyc(1'b0, 1'b1, 0, "dis_tick", 1'b0, S_IDLE);
        set_cfg(8'h01, 32'd10, 32'd50);
        cyc(1'b0, 1'b0, 0, "re_arm", 1'b0, S_ARM);
        cyc(1'b1, 1'b0, 0, "re_start", 1'b1, S_RUN);
        for (int k = 1; k <= 50; k++) cyc(1'b0, 1'b1, 0, $sformatf("re_tick%0d", k), ((k % 50) < 10), S_RUN);

        // Asynchronous reset between edges while the pulse is high
        i_pps = 1'b0;
        i_tick_us = 1'b0;
        #3;
        i_rst = 1'b1;
        #1;
        check("async_rst", 1'b0, S_IDLE);
        @(posedge i_clk);
        #1;
        check("rst_held", 1'b0, S_IDLE);
        i_rst = 1'b0;
        cyc(1'b0, 1'b0, 0, "post_rst_arm", 1'b0, S_ARM);
        cyc(1'b1, 1'b0, 1, "post_rst_nomatch", 1'b0, S_ARM);
        cyc(1'b0, 1'b1, 0, "post_rst_wait", 1'b0, S_ARM);
        cyc(1'b1, 1'b0, 0, "post_rst_start", 1'b1, S_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
